// File: rtl/uart_tx_arbiter_pkg.sv
// uart_tx_arbiter_pkg: shared state encoding and frame-time helper for the uart_tx arbiter
package uart_tx_arbiter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arbState_t;

    // One 10-bit frame plus two bit-times of margin, in system clocks
    function automatic int frameCycles(input int sysClock, input int baudRate);
        return 12 * (sysClock / baudRate);
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_priority_picker.sv
// rr_priority_picker: picks the first set request at or after the pointer, wrapping modulo NUM_REQ
module rr_priority_picker #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         i_ReqVec,
    input  logic [$clog2(NUM_REQ)-1:0] i_Ptr,
    output logic [NUM_REQ-1:0]         o_WinOneHot,
    output logic [$clog2(NUM_REQ)-1:0] o_WinIdx
);
    localparam int IW = $clog2(NUM_REQ);

    // Walk offsets from farthest to nearest so the nearest hit is written last
    always_comb begin
        o_WinIdx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (i_ReqVec[(int'(i_Ptr) + i) % NUM_REQ]) o_WinIdx = IW'((int'(i_Ptr) + i) % NUM_REQ);
        end
        o_WinOneHot = |i_ReqVec ? NUM_REQ'(1) << o_WinIdx : '0;
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one uart_tx among NUM_REQ byte producers, with a frame watchdog
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int SYS_CLOCK      = 50000000,
    parameter int UART_BAUDRATE  = 115200,
    parameter int TIMEOUT_CYCLES = frameCycles(SYS_CLOCK, UART_BAUDRATE)
) (
    input  logic                 i_SysClock,
    input  logic                 i_Reset,
    input  logic [NUM_REQ-1:0]   i_ReqValid,
    input  logic [NUM_REQ*8-1:0] i_ReqByte,
    output logic [NUM_REQ-1:0]   o_ReqAck,
    output logic [NUM_REQ-1:0]   o_ReqDone,
    output logic [NUM_REQ-1:0]   o_Grant,
    output logic                 o_TxValid,
    output logic [7:0]           o_TxByte,
    input  logic                 i_TxDone,
    output logic                 o_Busy,
    output logic                 o_Timeout
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

    arbState_t          state;
    logic [IW-1:0]      ptr;
    logic [IW-1:0]      owner;
    logic [IW-1:0]      winIdx;
    logic [NUM_REQ-1:0] winOneHot;
    logic [WW-1:0]      watchdog;
    logic               doneSeen;
    logic               wdExpired;

    rr_priority_picker #(.NUM_REQ(NUM_REQ)) picker (
        .i_ReqVec    (i_ReqValid),
        .i_Ptr       (ptr),
        .o_WinOneHot (winOneHot),
        .o_WinIdx    (winIdx)
    );

    // A done in the launch cycle cannot belong to the frame just started
    assign doneSeen  = i_TxDone && !o_TxValid;
    assign wdExpired = watchdog == WW'(TIMEOUT_CYCLES - 1);

    always_ff @(posedge i_SysClock) begin
        if (i_Reset) begin
            state     <= IDLE;
            ptr       <= '0;
            owner     <= '0;
            watchdog  <= '0;
            o_ReqAck  <= '0;
            o_ReqDone <= '0;
            o_Grant   <= '0;
            o_TxValid <= 1'b0;
            o_TxByte  <= 8'h00;
            o_Busy    <= 1'b0;
            o_Timeout <= 1'b0;
        end else begin
            o_TxValid <= 1'b0;
            o_ReqAck  <= '0;
            o_ReqDone <= '0;
            o_Timeout <= 1'b0;
            if (state == IDLE) begin
                if (|i_ReqValid) begin
                    owner     <= winIdx;
                    o_TxByte  <= i_ReqByte[{winIdx, 3'b000} +: 8];
                    o_TxValid <= 1'b1;
                    o_ReqAck  <= winOneHot;
                    o_Grant   <= winOneHot;
                    o_Busy    <= 1'b1;
                    watchdog  <= '0;
                    state     <= BUSY;
                end
            end else begin
                watchdog <= watchdog + 1'b1;
                if (doneSeen || wdExpired) begin
                    o_ReqDone <= doneSeen ? NUM_REQ'(1) << owner : '0;
                    o_Timeout <= !doneSeen;
                    ptr       <= owner == IW'(NUM_REQ - 1) ? '0 : owner + 1'b1;
                    o_Grant   <= '0;
                    o_Busy    <= 1'b0;
                    state     <= IDLE;
                end
            end
        end
    end

endmodule
